// File: rtl/fixed_point_alu.sv
// Registered fixed-point ALU: add/sub with carry, multiply, logic ops, shifts.
// Define ALU_SIGNED_MUL_EN to make op 010 a two's-complement multiply.
module fixed_point_alu #(
    parameter int DATA_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [2:0]            op,
    input  logic [DATA_W-1:0]     A,
    input  logic [DATA_W-1:0]     B,
    input  logic                  Cin,
    output logic [DATA_W-1:0]     Out1,
    output logic                  Cout,
    output logic [2*DATA_W-1:0]   Out2,
    output logic                  Zero,
    output logic                  Ovf
);

    localparam int W  = DATA_W;
    localparam int W2 = 2 * DATA_W;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [W-1:0]  bop;
    logic [W:0]    sum;
    logic [W2-1:0] prod;
    logic [W-1:0]  r1;
    logic          rc;
    logic [W2-1:0] r2;
    logic          rv;

    // Subtract shares the adder: A + ~B + Cin.
    always_comb begin
        bop = (op == OP_SUB) ? ~B : B;
        sum = {1'b0, A} + {1'b0, bop} + {{W{1'b0}}, Cin};
`ifdef ALU_SIGNED_MUL_EN
        prod = {{W{A[W-1]}}, A} * {{W{B[W-1]}}, B};
`else
        prod = {{W{1'b0}}, A} * {{W{1'b0}}, B};
`endif
    end

    always_comb begin
        r1 = '0;
        rc = 1'b0;
        r2 = '0;
        rv = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                r1 = sum[W-1:0];
                rc = sum[W];
                r2 = {{(W-1){1'b0}}, sum};
                rv = (A[W-1] == bop[W-1]) && (sum[W-1] != A[W-1]);
            end
            OP_MUL: begin
                r2 = prod;
                r1 = prod[W-1:0];
`ifdef ALU_SIGNED_MUL_EN
                rc = prod[W2-1:W] != {W{prod[W-1]}};
`else
                rc = |prod[W2-1:W];
`endif
            end
            OP_AND: begin
                r1 = A & B;
                r2 = {{W{1'b0}}, A & B};
            end
            OP_OR: begin
                r1 = A | B;
                r2 = {{W{1'b0}}, A | B};
            end
            OP_XOR: begin
                r1 = A ^ B;
                r2 = {{W{1'b0}}, A ^ B};
            end
            OP_SHL: begin
                r1 = {A[W-2:0], Cin};
                rc = A[W-1];
                r2 = {{W{1'b0}}, A[W-2:0], Cin};
            end
            OP_SHR: begin
                r1 = {Cin, A[W-1:1]};
                rc = A[0];
                r2 = {{W{1'b0}}, Cin, A[W-1:1]};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Out1 <= '0;
            Cout <= 1'b0;
            Out2 <= '0;
            Ovf  <= 1'b0;
        end else if (en) begin
            Out1 <= r1;
            Cout <= rc;
            Out2 <= r2;
            Ovf  <= rv;
        end
    end

    assign Zero = ~|Out2;

endmodule

// File: tb/tb_fixed_point_alu.sv
// Self-checking bench for fixed_point_alu: directed cases plus random ops
// against an integer-arithmetic reference model.
module tb_fixed_point_alu;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] op;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] Out1;
    logic       Cout;
    logic [7:0] Out2;
    logic       Zero;
    logic       Ovf;

    int total;
    int bad;

    logic [3:0] e1;
    logic       ec;
    logic [7:0] e2;
    logic       ev;

    fixed_point_alu #(.DATA_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .op   (op),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .Out1 (Out1),
        .Cout (Cout),
        .Out2 (Out2),
        .Zero (Zero),
        .Ovf  (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    // Reference: plain integer arithmetic on the operation's meaning.
    task automatic model(input int o, input int a, input int b, input int c);
        int s;
        int p;
        int r1;
        int r2;
        int co;
        int ov;
        r1 = 0; r2 = 0; co = 0; ov = 0;
        case (o)
            0: begin
                s  = a + b + c;
                r1 = s % 16;
                co = s / 16;
                r2 = s;
                p  = sx(a) + sx(b) + c;
                ov = (p > 7 || p < -8) ? 1 : 0;
            end
            1: begin
                s  = a + (15 - b) + c;
                r1 = s % 16;
                co = s / 16;
                r2 = s;
                p  = sx(a) - sx(b) - 1 + c;
                ov = (p > 7 || p < -8) ? 1 : 0;
            end
            2: begin
`ifdef ALU_SIGNED_MUL_EN
                p  = sx(a) * sx(b);
                r2 = (p + 256) % 256;
                co = (p > 7 || p < -8) ? 1 : 0;
`else
                p  = a * b;
                r2 = p;
                co = (p >= 16) ? 1 : 0;
`endif
                r1 = r2 % 16;
            end
            3: r1 = a & b;
            4: r1 = a | b;
            5: r1 = a ^ b;
            6: begin
                r1 = (a * 2 + c) % 16;
                co = a / 8;
            end
            default: begin
                r1 = c * 8 + a / 2;
                co = a % 2;
            end
        endcase
        if (o >= 3) r2 = r1;
        e1 = 4'(r1);
        ec = 1'(co);
        e2 = 8'(r2);
        ev = 1'(ov);
    endtask

    task automatic verify(input string tag);
        chk({tag, ".out1"}, 32'(Out1), 32'(e1));
        chk({tag, ".cout"}, 32'(Cout), 32'(ec));
        chk({tag, ".out2"}, 32'(Out2), 32'(e2));
        chk({tag, ".zero"}, 32'(Zero), 32'(e2 == 8'h00));
        chk({tag, ".ovf"},  32'(Ovf),  32'(ev));
    endtask

    task automatic issue(input int o, input int a, input int b, input int c);
        op  = 3'(o);
        A   = 4'(a);
        B   = 4'(b);
        Cin = 1'(c);
        en  = 1'b1;
        model(o, a, b, c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ro;
        int ra;
        int rb;
        int rcin;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en = 1'b0; op = 3'd0; A = 4'd0; B = 4'd0; Cin = 1'b0;
        e1 = 4'd0; ec = 1'b0; e2 = 8'd0; ev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        verify("reset");
        rst_n = 1'b1;

        issue(0, 3, 4, 1);
        verify("add");
        chk("add.out1k", 32'(Out1), 32'h8);
        chk("add.ovfk", 32'(Ovf), 32'h1);

        issue(1, 3, 4, 1);
        verify("sub34");
        chk("sub34.out1k", 32'(Out1), 32'hF);
        issue(1, 4, 3, 1);
        verify("sub43");
        chk("sub43.coutk", 32'(Cout), 32'h1);
        issue(1, 0, 0, 0);
        verify("sub00");

        issue(2, 3, 4, 0);
        verify("mul34");
        chk("mul34.out2k", 32'(Out2), 32'h0C);
        issue(2, 15, 2, 1);
        verify("mulf2");
`ifdef ALU_SIGNED_MUL_EN
        chk("mulf2.out2k", 32'(Out2), 32'hFE);
`else
        chk("mulf2.out2k", 32'(Out2), 32'h1E);
`endif

        issue(3, 10, 6, 0);
        verify("and");
        chk("and.out1k", 32'(Out1), 32'h2);
        issue(4, 10, 6, 0);
        verify("or");
        issue(5, 10, 6, 0);
        verify("xor");
        chk("xor.out1k", 32'(Out1), 32'hC);
        issue(6, 10, 6, 1);
        verify("shl");
        issue(7, 10, 6, 0);
        verify("shr");

        issue(0, 15, 15, 1);
        verify("addff");
        chk("addff.out2k", 32'(Out2), 32'h1F);

        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op  = 3'($urandom_range(0, 7));
            A   = 4'($urandom);
            B   = 4'($urandom);
            Cin = 1'($urandom);
            @(posedge clk);
            #1;
            verify("hold");
        end

        // Asynchronous reset away from any clock edge.
        issue(0, 5, 6, 0);
        #2;
        rst_n = 1'b0;
        #1;
        e1 = 4'd0; ec = 1'b0; e2 = 8'd0; ev = 1'b0;
        verify("areset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            ro   = int'($urandom_range(0, 7));
            ra   = int'($urandom_range(0, 15));
            rb   = int'($urandom_range(0, 15));
            rcin = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                en  = 1'b0;
                op  = 3'(ro);
                A   = 4'(ra);
                B   = 4'(rb);
                Cin = 1'(rcin);
                @(posedge clk);
                #1;
            end else begin
                issue(ro, ra, rb, rcin);
            end
            verify("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
